// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding op over a valid/ready data bus,
// with lane steering, sign/zero extension, misalignment trapping and flush.
module load_store_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_sign,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic [RD_W-1:0]       i_req_rd,
    input  logic                  i_flush,
    output logic                  o_bus_valid,
    input  logic                  i_bus_ready,
    output logic                  o_bus_we,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W-1:0]     o_bus_wdata,
    output logic [DATA_W/8-1:0]   o_bus_wstrb,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_W-1:0]     i_bus_rdata,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_wb,
    output logic                  o_rsp_err,
    output logic [RD_W-1:0]       o_rsp_rd,
    output logic [DATA_W-1:0]     o_rsp_data,
    output logic                  o_busy
);
    localparam int NBYTES = DATA_W / 8;
    localparam int OFFW   = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nx;

    logic              r_we, r_sign, r_err, r_kill;
    logic [1:0]        r_size;
    logic [OFFW-1:0]   r_off;
    logic [RD_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_data;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [NBYTES-1:0] r_bus_wstrb;

    logic              accept, bad, ld_done, fill;
    logic [2:0]        amask;
    logic [NBYTES-1:0] req_strb;
    logic [DATA_W-1:0] ld_shift, ld_data;
    int                req_off, req_nb, ld_nb;

    // Request decode: alignment/legality and the strobe pattern for the bus lanes.
    always_comb begin
        amask    = 3'((4'd1 << i_req_size) - 4'd1);
        bad      = (|(i_req_addr[2:0] & amask)) || ((DATA_W == 32) && (i_req_size == 2'd3));
        accept   = i_req_valid && (state == IDLE) && !i_flush;
        req_off  = int'(i_req_addr[OFFW-1:0]);
        req_nb   = 1 << i_req_size;
        req_strb = '0;
        for (int i = 0; i < NBYTES; i++)
            req_strb[i] = (i >= req_off) && (i < req_off + req_nb);
    end

    // Load return path: shift the addressed lane down, then extend above NB bytes.
    always_comb begin
        ld_shift = i_bus_rdata >> {r_off, 3'b000};
        ld_nb    = 1 << r_size;
        case (r_size)
            2'd0:    fill = r_sign && ld_shift[7];
            2'd1:    fill = r_sign && ld_shift[15];
            2'd2:    fill = r_sign && ld_shift[31];
            default: fill = r_sign && ld_shift[DATA_W-1];
        endcase
        ld_data = '0;
        for (int i = 0; i < NBYTES; i++)
            ld_data[8*i +: 8] = (i < ld_nb) ? ld_shift[8*i +: 8] : {8{fill}};
        ld_done = ((state == REQ) && i_bus_ready && !r_we && i_bus_rvalid) ||
                  ((state == WAIT) && i_bus_rvalid);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // A flush coinciding with the handshake still squashes the response; a load
    // already on the bus must be drained through WAIT before going idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = bad ? RESP : REQ;
            REQ: begin
                if (i_bus_ready) begin
                    if (r_we || i_bus_rvalid) state_nx = i_flush ? IDLE : RESP;
                    else                      state_nx = WAIT;
                end else if (i_flush) begin
                    state_nx = IDLE;
                end
            end
            WAIT: if (i_bus_rvalid) state_nx = (r_kill || i_flush) ? IDLE : RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_err       <= 1'b0;
            r_kill      <= 1'b0;
            r_size      <= '0;
            r_off       <= '0;
            r_rd        <= '0;
            r_data      <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else begin
            if (accept) begin
                r_we        <= i_req_we;
                r_sign      <= i_req_sign;
                r_size      <= i_req_size;
                r_off       <= i_req_addr[OFFW-1:0];
                r_rd        <= i_req_rd;
                r_err       <= bad;
                r_kill      <= 1'b0;
                r_data      <= bad ? DATA_W'(i_req_addr) : '0;
                r_bus_we    <= i_req_we;
                r_bus_addr  <= {i_req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                r_bus_wdata <= i_req_wdata << {i_req_addr[OFFW-1:0], 3'b000};
                r_bus_wstrb <= req_strb;
            end
            if (ld_done) r_data <= ld_data;
            if (i_flush && (((state == REQ) && i_bus_ready) || (state == WAIT)))
                r_kill <= 1'b1;
        end
    end

    assign o_req_ready = (state == IDLE);
    assign o_busy      = !o_req_ready;
    assign o_bus_valid = (state == REQ);
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_wstrb = r_bus_wstrb;
    assign o_rsp_valid = (state == RESP) && !i_flush;
    assign o_rsp_wb    = o_rsp_valid && !r_we && !r_err;
    assign o_rsp_err   = o_rsp_valid && r_err;
    assign o_rsp_rd    = r_rd;
    assign o_rsp_data  = r_data;
endmodule
